// File: rtl/btb_assoc.sv
// btb_assoc: 2-way set-associative, partially tagged branch target buffer.
//
// Ports:
//   clk              - system clock, rising edge
//   rst              - asynchronous, active-high reset (clears valid and LRU bits)
//   enable           - global enable; 0 stalls all state changes
//   flush            - invalidate every entry and clear LRU on the next edge
//   lookup_pc        - current fetch PC, looked up combinationally
//   hit              - lookup_pc matches a valid entry
//   predicted_target - cached target on hit, 0 on miss
//   upd_en           - write request from decode
//   upd_pc           - PC of the resolved branch
//   upd_target       - actual branch target
//
// PC split: idx = pc[IDX_W-1:0], tag = pc[IDX_W+TAG_W-1:IDX_W]; upper bits are ignored,
// so partial-tag aliasing is accepted. LRU bit per set holds the index of the least
// recently used way.
module btb_assoc #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              hit,
   output logic [ADDR_W-1:0] predicted_target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target
);

   localparam int unsigned SETS = 2 ** IDX_W;

   logic [SETS-1:0]   valid0_q, valid0_d;
   logic [SETS-1:0]   valid1_q, valid1_d;
   logic [SETS-1:0]   lru_q, lru_d;
   logic [TAG_W-1:0]  tag0_q [SETS];
   logic [TAG_W-1:0]  tag1_q [SETS];
   logic [ADDR_W-1:0] tgt0_q [SETS];
   logic [ADDR_W-1:0] tgt1_q [SETS];

   logic [IDX_W-1:0] l_idx, u_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   logic             hit0, hit1;
   logic             match0, match1;
   logic             wsel;
   logic             upd_we;

   assign l_idx = lookup_pc[IDX_W-1:0];
   assign l_tag = lookup_pc[IDX_W+TAG_W-1:IDX_W];
   assign u_idx = upd_pc[IDX_W-1:0];
   assign u_tag = upd_pc[IDX_W+TAG_W-1:IDX_W];

   generate
      if (IDX_W + TAG_W < ADDR_W) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^{lookup_pc[ADDR_W-1:IDX_W+TAG_W], upd_pc[ADDR_W-1:IDX_W+TAG_W]};
      end
   endgenerate

   // Lookup: at most one way can match because updates never create duplicates.
   assign hit0 = valid0_q[l_idx] && (tag0_q[l_idx] == l_tag);
   assign hit1 = valid1_q[l_idx] && (tag1_q[l_idx] == l_tag);
   assign hit  = hit0 || hit1;

   always_comb begin
      predicted_target = '0;
      if (hit0) begin
         predicted_target = tgt0_q[l_idx];
      end else if (hit1) begin
         predicted_target = tgt1_q[l_idx];
      end
   end

   // Victim selection: matching way, then first invalid way, then LRU way.
   assign match0 = valid0_q[u_idx] && (tag0_q[u_idx] == u_tag);
   assign match1 = valid1_q[u_idx] && (tag1_q[u_idx] == u_tag);

   always_comb begin
      if (match0) begin
         wsel = 1'b0;
      end else if (match1) begin
         wsel = 1'b1;
      end else if (!valid0_q[u_idx]) begin
         wsel = 1'b0;
      end else if (!valid1_q[u_idx]) begin
         wsel = 1'b1;
      end else begin
         wsel = lru_q[u_idx];
      end
   end

   assign upd_we = enable && upd_en && !flush;

   always_comb begin
      valid0_d = valid0_q;
      valid1_d = valid1_q;
      lru_d    = lru_q;
      if (enable) begin
         if (flush) begin
            valid0_d = '0;
            valid1_d = '0;
            lru_d    = '0;
         end else begin
            // Hitting way becomes MRU; a hit in way0 makes way1 the LRU way.
            if (hit) begin
               lru_d[l_idx] = hit0;
            end
            // Applied after the lookup so the update wins on a same-set collision.
            if (upd_en) begin
               if (wsel) begin
                  valid1_d[u_idx] = 1'b1;
               end else begin
                  valid0_d[u_idx] = 1'b1;
               end
               lru_d[u_idx] = ~wsel;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid0_q <= '0;
         valid1_q <= '0;
         lru_q    <= '0;
      end else begin
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         lru_q    <= lru_d;
      end
   end

   // Tags and targets need no reset: they are only observed through valid bits.
   always_ff @(posedge clk) begin
      if (upd_we) begin
         if (wsel) begin
            tag1_q[u_idx] <= u_tag;
            tgt1_q[u_idx] <= upd_target;
         end else begin
            tag0_q[u_idx] <= u_tag;
            tgt0_q[u_idx] <= upd_target;
         end
      end
   end

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: scoreboard bench for btb_assoc. Stimulus pushes the expected
// {hit, target} of each lookup into a queue; a monitor pops and compares at the
// falling edge whenever a lookup is presented.
module tb_btb_assoc;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        flush;
   logic [15:0] lookup_pc;
   logic        hit;
   logic [15:0] predicted_target;
   logic        upd_en;
   logic [15:0] upd_pc;
   logic [15:0] upd_target;

   logic        look_valid;
   logic        done;
   logic [16:0] exp_q [$];
   int          n_tests;
   int          n_fail;

   // TAG_W=5 so that 0x0092 carries a different tag from 0x0012 (bit 7 is tagged).
   btb_assoc #(
      .ADDR_W(16),
      .IDX_W (3),
      .TAG_W (5)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .flush           (flush),
      .lookup_pc       (lookup_pc),
      .hit             (hit),
      .predicted_target(predicted_target),
      .upd_en          (upd_en),
      .upd_pc          (upd_pc),
      .upd_target      (upd_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus, driven 1 time unit after the rising edge.
   task automatic step(input logic u, input logic [15:0] upc, input logic [15:0] utg,
                       input logic lk, input logic [15:0] lpc, input logic eh,
                       input logic [15:0] et, input logic fl, input logic en);
      @(posedge clk);
      #1;
      upd_en     = u;
      upd_pc     = upc;
      upd_target = utg;
      lookup_pc  = lk ? lpc : 16'h0007;  // set 7 is never written, so idle lookups miss
      look_valid = lk;
      flush      = fl;
      enable     = en;
      if (lk) exp_q.push_back({eh, et});
   endtask

   task automatic wr(input logic [15:0] pc, input logic [15:0] tgt);
      step(1'b1, pc, tgt, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
   endtask

   task automatic lk(input logic [15:0] pc, input logic eh, input logic [15:0] et);
      step(1'b0, 16'h0, 16'h0, 1'b1, pc, eh, et, 1'b0, 1'b1);
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
   endtask

   // Monitor / scoreboard
   initial begin
      n_tests = 0;
      n_fail  = 0;
      forever begin
         @(negedge clk);
         if (look_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL lookup_%h: got hit=%0b tgt=%h, required no pending lookup",
                        lookup_pc, hit, predicted_target);
            end else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               if ({hit, predicted_target} !== e) begin
                  n_fail++;
                  $display("FAIL lookup_%h: got hit=%0b tgt=%h, required hit=%0b tgt=%h",
                           lookup_pc, hit, predicted_target, e[16], e[15:0]);
               end
            end
         end
         if (done) begin
            n_tests++;
            if (exp_q.size() != 0) begin
               n_fail++;
               $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required summary");
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b1;
      done       = 1'b0;
      enable     = 1'b1;
      flush      = 1'b0;
      upd_en     = 1'b0;
      upd_pc     = '0;
      upd_target = '0;
      lookup_pc  = '0;
      look_valid = 1'b0;

      // Miss while in reset and just after.
      lk(16'h0012, 1'b0, 16'h0000);
      idle();
      rst = 1'b0;
      lk(16'h0012, 1'b0, 16'h0000);

      // First write and visibility, tag discrimination.
      wr(16'h0012, 16'h0100);
      lk(16'h0012, 1'b1, 16'h0100);
      lk(16'h0092, 1'b0, 16'h0000);

      // Conflict in set 2: 0x0022 becomes LRU and is evicted by 0x0032.
      wr(16'h0022, 16'h0200);
      lk(16'h0012, 1'b1, 16'h0100);
      wr(16'h0032, 16'h0300);
      lk(16'h0022, 1'b0, 16'h0000);
      lk(16'h0012, 1'b1, 16'h0100);
      lk(16'h0032, 1'b1, 16'h0300);

      // Rewrite in place, no duplicate; partial-tag alias 0x0112 -> 0x0012.
      wr(16'h0012, 16'h0400);
      lk(16'h0012, 1'b1, 16'h0400);
      lk(16'h0032, 1'b1, 16'h0300);
      lk(16'h0112, 1'b1, 16'h0400);
      wr(16'h0052, 16'h0600);           // LRU=way1 -> replaces 0x0032
      lk(16'h0032, 1'b0, 16'h0000);
      lk(16'h0052, 1'b1, 16'h0600);
      lk(16'h0012, 1'b1, 16'h0400);     // LRU now way1

      // Same-set lookup and update: update's LRU (way0 LRU) must win.
      step(1'b1, 16'h0032, 16'h0700, 1'b1, 16'h0012, 1'b1, 16'h0400, 1'b0, 1'b1);
      wr(16'h0062, 16'h0800);           // replaces way0 (0x0012)
      lk(16'h0012, 1'b0, 16'h0000);
      lk(16'h0032, 1'b1, 16'h0700);
      lk(16'h0062, 1'b1, 16'h0800);

      // Flush beats a simultaneous update.
      step(1'b1, 16'h0044, 16'h0500, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
      lk(16'h0044, 1'b0, 16'h0000);
      lk(16'h0032, 1'b0, 16'h0000);
      lk(16'h0062, 1'b0, 16'h0000);

      // Stall: outputs still live, write ignored.
      wr(16'h0012, 16'h0100);
      step(1'b1, 16'h0044, 16'h0500, 1'b1, 16'h0012, 1'b1, 16'h0100, 1'b0, 1'b0);
      lk(16'h0044, 1'b0, 16'h0000);
      lk(16'h0012, 1'b1, 16'h0100);

      // Asynchronous reset between edges, with a write pending that must be lost.
      @(posedge clk);
      #1;
      lookup_pc  = 16'h0012;
      look_valid = 1'b1;
      upd_en     = 1'b1;
      upd_pc     = 16'h0022;
      upd_target = 16'h0200;
      exp_q.push_back({1'b0, 16'h0000});
      #2;
      rst = 1'b1;
      idle();
      rst = 1'b0;
      lk(16'h0022, 1'b0, 16'h0000);
      lk(16'h0012, 1'b0, 16'h0000);
      wr(16'h0012, 16'h0100);
      lk(16'h0012, 1'b1, 16'h0100);

      idle();
      done = 1'b1;
   end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised next-generation branch target buffer: 2-way set-associative, tagged, with per-entry valid bits and per-set LRU replacement.
- Sits in the fetch stage. Looked up combinationally with the current fetch PC; written from decode with the resolved target of a taken or mispredicted branch.
- Adds what the single-way untagged BTB lacks: hit/miss indication, aliasing protection via tags, conflict tolerance, and a one-cycle flush.

Parameters:
- ADDR_W, 16, PC and target width.
- IDX_W, 3, set-index bits; SETS = 2**IDX_W.
- TAG_W, 4, partial-tag bits; requires IDX_W+TAG_W <= ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  global enable; 0 = stall, no state changes
- flush  input  1  invalidate all entries
- lookup_pc  input  ADDR_W  current fetch PC
- hit  output  1  lookup_pc matches a valid entry
- predicted_target  output  ADDR_W  cached target on hit, 0 on miss
- upd_en  input  1  write request from decode
- upd_pc  input  ADDR_W  PC of the resolved branch
- upd_target  input  ADDR_W  actual branch target

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state clears immediately on rst=1, independent of clk.
- Address split:
  - idx = pc[IDX_W-1:0]
  - tag = pc[IDX_W+TAG_W-1:IDX_W]
  - Remaining upper bits are ignored, so partial-tag aliasing is accepted.
- Storage per set: 2 ways of {valid, tag[TAG_W], target[ADDR_W]} plus 1 LRU bit. LRU=0 means way0 is least recent.
- Reset: all valid=0, all LRU=0. Targets need not be cleared. Outputs hit=0 and predicted_target=0 while rst=1 and after reset until a write occurs.
- Lookup (combinational, zero latency):
  - Way w hits if valid[w] && tag[w]==tag(lookup_pc).
  - hit = OR of the two ways. predicted_target = target of the hitting way, else 0.
  - Lookup ignores enable.
  - No write bypass: a write becomes visible on the cycle after its clock edge.
- Update, at posedge clk when enable && upd_en && !flush, on set idx(upd_pc):
  - Tag match with a valid way: overwrite that way's target only. Never create duplicates.
  - Otherwise, if way0 is invalid: allocate way0.
  - Otherwise, if way1 is invalid: allocate way1.
  - Otherwise: allocate the LRU way.
  - Allocation sets valid=1 and writes tag and target.
  - The written way becomes MRU: LRU is set to point at the other way.
- LRU on lookup: at posedge, if enable && hit, the hitting way becomes MRU in set idx(lookup_pc).
  - If the update and the lookup address the same set in the same cycle, the update's LRU result wins.
- Flush: at posedge, if enable && flush, clear all valid bits and LRU bits. Flush has priority over upd_en and over lookup LRU updates. Takes exactly one cycle.
- enable=0: no valid, tag, target or LRU changes. Outputs still reflect current contents.
- Reset asserted mid-operation: any pending write that cycle is lost. The next lookup after deassertion misses.

Test Plan:
- Reset then lookup_pc=0x0012 -> hit=0, predicted_target=0x0000.
- upd_pc=0x0012, upd_target=0x0100, enable=1, one edge; then lookup 0x0012 -> hit=1, target=0x0100. Lookup 0x0092 (same idx, different tag) -> hit=0.
- Conflict sequence in set 2:
  - Write 0x0012->0x0100, then 0x0022->0x0200.
  - Look up 0x0012 (makes it MRU).
  - Write 0x0032->0x0300.
  - Result: 0x0022 misses; 0x0012->0x0100 and 0x0032->0x0300 hit.
- Rewrite 0x0012->0x0400 with both ways full -> lookup returns 0x0400. The other way is unchanged, so no duplicate entry.
- flush=1 and upd_en=1 (0x0044->0x0500) on the same edge -> all lookups miss, including 0x0044. enable=0 with upd_en=1 -> no entry created.
- Assert rst between clock edges while the buffer is populated -> hit drops to 0 immediately, with no clock edge needed. After release, a write and a lookup of 0x0012 work normally.
